mf_disp_ahb_cmd_bridge: RTL and testbench

//  AHB-Lite slave that initiates cmd_wr_vld/addr/data writes into the command register block.

---
 rtl/mf_disp_ahb_cmd_bridge_pkg.sv | 32 +++
 rtl/mf_disp_ahb_cmd_bridge.sv | 157 +++++++++++++++
 tb/tb_mf_disp_ahb_cmd_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mf_disp_ahb_cmd_bridge_pkg.sv
// Register map, AHB encodings and bridge state encoding shared by the
// display command bridge and its users.
package mf_disp_ahb_cmd_bridge_pkg;

  localparam logic [7:0] OFS_CTL0   = 8'h00;
  localparam logic [7:0] OFS_CTL1   = 8'h04;
  localparam logic [7:0] OFS_STATUS = 8'h08;
  localparam logic [7:0] OFS_CTL9   = 8'h24;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } bridge_st_e;

  // Only aligned word accesses inside the decoded register window are legal.
  function automatic logic xfer_err(input logic [2:0] size,
                                    input logic [7:0] ofs,
                                    input logic [7:0] span);
    return (size != HSIZE_WORD) || (ofs[1:0] != 2'b00) || (ofs > span);
  endfunction

endpackage

// File: rtl/mf_disp_ahb_cmd_bridge.sv
// AHB-Lite slave that forwards register writes to the command register block
// through a one-entry buffer and serves CTL0 shadow / STATUS read-back.
module mf_disp_ahb_cmd_bridge
  import mf_disp_ahb_cmd_bridge_pkg::*;
#(
  parameter logic [7:0]  REG_SPAN = OFS_CTL9,
  parameter int unsigned FCNT_W   = 16
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        cmd_wr_vld,
  output logic [7:0]  cmd_wr_addr,
  output logic [31:0] cmd_wr_data,
  input  logic        cmd_wr_rdy,
  input  logic        disp_frame_done,
  input  logic        disp_busy
);

  // state   | meaning
  // ST_IDLE | no data phase active
  // ST_RD   | read data phase, zero wait
  // ST_WR   | write data phase, waits while buffer is full and sink stalls
  // ST_ERR1 | first error cycle (HREADYOUT=0, HRESP=1)
  // ST_ERR2 | second error cycle (HREADYOUT=1, HRESP=1)
  bridge_st_e state_q;
  logic [7:0] ofs_q;

  logic              pend_q, pend_d;
  logic [7:0]        cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_data_q, cmd_data_d;
  logic [2:0]        shadow_q, shadow_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [15:0]       fcnt_ext;

  logic addr_acc;
  logic addr_err;
  logic wr_is_status;
  logic wr_ok;
  logic wr_done;
  logic buf_load;
  logic status_clr;
  logic addr_unused;

  assign addr_unused = ^{HADDR[31:8], HTRANS[0]};

  assign addr_acc     = HSEL & HREADY & HTRANS[1];
  assign addr_err     = xfer_err(HSIZE, HADDR[7:0], REG_SPAN);
  assign wr_is_status = (ofs_q == OFS_STATUS);
  assign wr_ok        = wr_is_status | ~pend_q | cmd_wr_rdy;
  assign wr_done      = (state_q == ST_WR) & wr_ok;
  assign buf_load     = wr_done & ~wr_is_status;
  assign status_clr   = wr_done & wr_is_status & HWDATA[0];

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ofs_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_ERR1: state_q <= ST_ERR2;
        default: begin
          if (HREADY) begin
            if (addr_acc) begin
              ofs_q <= HADDR[7:0];
              if (addr_err)    state_q <= ST_ERR1;
              else if (HWRITE) state_q <= ST_WR;
              else             state_q <= ST_RD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    case (state_q)
      ST_WR:   HREADYOUT = wr_ok;
      ST_ERR1: HREADYOUT = 1'b0;
      default: HREADYOUT = 1'b1;
    endcase
  end

  assign HRESP = (state_q == ST_ERR1) | (state_q == ST_ERR2);

  // A reload in the same cycle as an accept keeps the entry valid.
  always_comb begin
    pend_d     = pend_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    shadow_d   = shadow_q;
    if (pend_q && cmd_wr_rdy) pend_d = 1'b0;
    if (buf_load) begin
      pend_d     = 1'b1;
      cmd_addr_d = ofs_q;
      cmd_data_d = HWDATA;
      if (ofs_q == OFS_CTL0) shadow_d = HWDATA[2:0];
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      pend_q     <= 1'b0;
      cmd_addr_q <= 8'h00;
      cmd_data_q <= 32'h0;
      shadow_q   <= 3'b000;
    end else begin
      pend_q     <= pend_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      shadow_q   <= shadow_d;
    end
  end

  assign cmd_wr_vld  = pend_q;
  assign cmd_wr_addr = cmd_addr_q;
  assign cmd_wr_data = cmd_data_q;

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      fcnt_q <= '0;
    end else if (status_clr) begin
      fcnt_q <= '0;
    end else if (disp_frame_done) begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  always_comb begin
    fcnt_ext             = '0;
    fcnt_ext[FCNT_W-1:0] = fcnt_q;
  end

  always_comb begin
    HRDATA = 32'h0;
    if (state_q == ST_RD) begin
      case (ofs_q)
        OFS_CTL0:   HRDATA = {29'b0, shadow_q};
        OFS_STATUS: HRDATA = {fcnt_ext, 14'b0, pend_q, disp_busy};
        default:    HRDATA = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mf_disp_ahb_cmd_bridge.sv
// Directed bench for the display command bridge; a second instance with a
// 4-bit frame counter exercises counter wrap.
module tb_mf_disp_ahb_cmd_bridge;
  import mf_disp_ahb_cmd_bridge_pkg::*;

  logic        sys_clk;
  logic        resetn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        cmd_wr_vld;
  logic [7:0]  cmd_wr_addr;
  logic [31:0] cmd_wr_data;
  logic        cmd_wr_rdy;
  logic        disp_frame_done;
  logic        disp_busy;

  logic [31:0] w4_hrdata;
  logic        w4_hreadyout;
  logic        w4_hresp;
  logic        w4_vld;
  logic [7:0]  w4_addr;
  logic [31:0] w4_data;

  int          n_vec = 0;
  int          n_err = 0;
  int          vld_cycles = 0;
  logic [39:0] acc_q[$];
  logic        pulse_in_dp = 1'b0;

  assign HREADY = HREADYOUT;

  mf_disp_ahb_cmd_bridge u_dut (
    .sys_clk(sys_clk), .resetn(resetn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .cmd_wr_vld(cmd_wr_vld), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
    .cmd_wr_rdy(cmd_wr_rdy), .disp_frame_done(disp_frame_done), .disp_busy(disp_busy)
  );

  mf_disp_ahb_cmd_bridge #(.FCNT_W(4)) u_dut_w4 (
    .sys_clk(sys_clk), .resetn(resetn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(w4_hrdata), .HREADYOUT(w4_hreadyout), .HRESP(w4_hresp),
    .cmd_wr_vld(w4_vld), .cmd_wr_addr(w4_addr), .cmd_wr_data(w4_data),
    .cmd_wr_rdy(cmd_wr_rdy), .disp_frame_done(disp_frame_done), .disp_busy(disp_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (resetn && cmd_wr_vld) begin
      vld_cycles++;
      if (cmd_wr_rdy) acc_q.push_back({cmd_wr_addr, cmd_wr_data});
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz,
                          output logic rdy0, output logic resp0, output logic resp_last,
                          output int waits, output logic dp_vld);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {24'h0, a}; HSIZE = sz;
    @(posedge sys_clk); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = d;
    disp_frame_done = pulse_in_dp;
    waits = 0;
    @(negedge sys_clk);
    rdy0 = HREADYOUT; resp0 = HRESP; dp_vld = cmd_wr_vld;
    while (!HREADYOUT && waits < 20) begin
      waits++;
      @(posedge sys_clk); #1;
      disp_frame_done = 1'b0;
      @(negedge sys_clk);
    end
    resp_last = HRESP;
    chk_val("wr_timeout", 32'(waits >= 20), 32'd0);
    @(posedge sys_clk); #1;
    disp_frame_done = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [31:0] d_w4,
                         output logic rdy, output logic resp);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {24'h0, a}; HSIZE = HSIZE_WORD;
    @(posedge sys_clk); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    @(negedge sys_clk);
    d = HRDATA; d_w4 = w4_hrdata; rdy = HREADYOUT; resp = HRESP;
    @(posedge sys_clk); #1;
  endtask

  task automatic idle_xfer(input string tag, input logic sel, input logic [1:0] tr, input logic wr);
    HSEL = sel; HTRANS = tr; HWRITE = wr; HADDR = 32'h4; HSIZE = HSIZE_WORD; HWDATA = 32'hDEAD;
    @(posedge sys_clk); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    @(negedge sys_clk);
    chk_val({tag, "_rdy"}, 32'(HREADYOUT), 32'd1);
    chk_val({tag, "_resp"}, 32'(HRESP), 32'd0);
    @(posedge sys_clk); #1;
  endtask

  task automatic pulse_frame(input int n);
    for (int i = 0; i < n; i++) begin
      disp_frame_done = 1'b1;
      @(posedge sys_clk); #1;
      disp_frame_done = 1'b0;
      @(posedge sys_clk); #1;
    end
  endtask

  initial begin
    logic        r0, p0, pl, dv, rr, rp;
    int          wt, n0, vc;
    logic [31:0] rd, rd4;

    resetn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
    HSIZE = HSIZE_WORD; HWDATA = '0; cmd_wr_rdy = 1'b1; disp_frame_done = 1'b0; disp_busy = 1'b0;

    #2;
    chk_val("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk_val("rst_hresp", 32'(HRESP), 32'd0);
    chk_val("rst_hrdata", HRDATA, 32'h0);
    chk_val("rst_vld", 32'(cmd_wr_vld), 32'd0);
    chk_val("rst_addr", 32'(cmd_wr_addr), 32'h0);
    chk_val("rst_data", cmd_wr_data, 32'h0);
    #20 resetn = 1'b1;
    @(posedge sys_clk); #1;

    // 1: single write, one-cycle pulse one cycle after the data phase
    do_write(OFS_CTL0, 32'h7, HSIZE_WORD, r0, p0, pl, wt, dv);
    chk_val("t1_dp_rdy", 32'(r0), 32'd1);
    chk_val("t1_dp_vld", 32'(dv), 32'd0);
    @(negedge sys_clk);
    chk_val("t1_vld", 32'(cmd_wr_vld), 32'd1);
    chk_val("t1_addr", 32'(cmd_wr_addr), 32'h00);
    chk_val("t1_data", cmd_wr_data, 32'h7);
    @(negedge sys_clk);
    chk_val("t1_vld_drop", 32'(cmd_wr_vld), 32'd0);
    @(posedge sys_clk); #1;
    do_read(OFS_CTL0, rd, rd4, rr, rp);
    chk_val("t1_rd_ctl0", rd, 32'h7);

    // 2: back-to-back writes against a stalled sink
    cmd_wr_rdy = 1'b0;
    n0 = acc_q.size();
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h4; HSIZE = HSIZE_WORD;
    @(posedge sys_clk); #1;
    HWDATA = 32'h1;
    @(negedge sys_clk);
    chk_val("t2_dp1_rdy", 32'(HREADYOUT), 32'd1);
    @(posedge sys_clk); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = 32'h2;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk_val("t2_wait_rdy", 32'(HREADYOUT), 32'd0);
      chk_val("t2_hold_data", cmd_wr_data, 32'h1);
      @(posedge sys_clk); #1;
    end
    cmd_wr_rdy = 1'b1;
    @(negedge sys_clk);
    chk_val("t2_release_rdy", 32'(HREADYOUT), 32'd1);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    chk_val("t2_vld2", 32'(cmd_wr_vld), 32'd1);
    chk_val("t2_data2", cmd_wr_data, 32'h2);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk_val("t2_count", 32'(acc_q.size() - n0), 32'd2);
    if (acc_q.size() >= n0 + 2) begin
      chk_val("t2_first", acc_q[n0][31:0], 32'h1);
      chk_val("t2_second", acc_q[n0+1][31:0], 32'h2);
      chk_val("t2_addr", 32'(acc_q[n0+1][39:32]), 32'h04);
    end

    // read-after-write sees the new CTL0 value before the sink accepts
    cmd_wr_rdy = 1'b0;
    do_write(OFS_CTL0, 32'h5, HSIZE_WORD, r0, p0, pl, wt, dv);
    do_read(OFS_CTL0, rd, rd4, rr, rp);
    chk_val("raw_ctl0", rd, 32'h5);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("raw_status_pend", rd, 32'h2);
    do_read(OFS_CTL1, rd, rd4, rr, rp);
    chk_val("rd_ctl1_zero", rd, 32'h0);
    cmd_wr_rdy = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    chk_val("raw_accept", acc_q[$][31:0], 32'h5);

    // 3: error responses, never forwarded
    n0 = acc_q.size();
    do_write(OFS_CTL0, 32'h1, 3'b000, r0, p0, pl, wt, dv);
    chk_val("t3_byte_e1", {30'b0, r0, p0}, 32'b01);
    chk_val("t3_byte_e2", {30'b0, pl, 1'b0}, 32'b10);
    chk_val("t3_byte_waits", 32'(wt), 32'd1);
    do_write(8'h28, 32'h1, HSIZE_WORD, r0, p0, pl, wt, dv);
    chk_val("t3_range_e1", {30'b0, r0, p0}, 32'b01);
    chk_val("t3_range_e2", {30'b0, pl, 1'b0}, 32'b10);
    do_write(8'h02, 32'h1, HSIZE_WORD, r0, p0, pl, wt, dv);
    chk_val("t3_align_e1", {30'b0, r0, p0}, 32'b01);
    chk_val("t3_align_e2", {30'b0, pl, 1'b0}, 32'b10);
    @(posedge sys_clk); #1;
    chk_val("t3_no_cmd", 32'(acc_q.size() - n0), 32'd0);
    do_read(OFS_CTL0, rd, rd4, rr, rp);
    chk_val("t3_ctl0_kept", rd, 32'h5);
    do_write(OFS_CTL9, 32'h55, HSIZE_WORD, r0, p0, pl, wt, dv);
    chk_val("t3_ctl9_ok", {30'b0, r0, p0}, 32'b10);
    @(posedge sys_clk); #1;
    chk_val("t3_ctl9_fwd", acc_q[$][39:8], {8'h24, 24'h000000});

    // 4: frame counter, clear priority and wrap
    pulse_frame(3);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t4_cnt3", rd, 32'h0003_0000);
    disp_busy = 1'b1;
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t4_busy", rd, 32'h0003_0001);
    disp_busy = 1'b0;
    n0 = acc_q.size();
    do_write(OFS_STATUS, 32'h0, HSIZE_WORD, r0, p0, pl, wt, dv);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t4_noclr", rd, 32'h0003_0000);
    pulse_in_dp = 1'b1;
    do_write(OFS_STATUS, 32'h1, HSIZE_WORD, r0, p0, pl, wt, dv);
    pulse_in_dp = 1'b0;
    chk_val("t4_clr_nowait", 32'(wt), 32'd0);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t4_clr_wins", rd, 32'h0);
    chk_val("t4_status_not_fwd", 32'(acc_q.size() - n0), 32'd0);
    pulse_frame(15);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t4_w4_max", rd4, 32'h000F_0000);
    pulse_frame(1);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t4_w4_wrap", rd4, 32'h0);
    chk_val("t4_w16_cnt", rd, 32'h0010_0000);

    // 6: IDLE/BUSY and unselected cycles have no effect
    n0 = acc_q.size();
    vc = vld_cycles;
    idle_xfer("t6_idle", 1'b1, HTRANS_IDLE, 1'b1);
    idle_xfer("t6_busy_w", 1'b1, HTRANS_BUSY, 1'b1);
    do_read(OFS_CTL0, rd, rd4, rr, rp);
    chk_val("t6_rd", rd, 32'h5);
    idle_xfer("t6_busy_r", 1'b1, HTRANS_BUSY, 1'b0);
    idle_xfer("t6_unsel", 1'b0, HTRANS_NONSEQ, 1'b1);
    chk_val("t6_no_cmd", 32'(vld_cycles - vc), 32'd0);

    // 5: asynchronous reset with a write pending
    cmd_wr_rdy = 1'b0;
    do_write(OFS_CTL1, 32'hAB, HSIZE_WORD, r0, p0, pl, wt, dv);
    @(negedge sys_clk);
    chk_val("t5_pending", {cmd_wr_vld, cmd_wr_data[30:0]}, 32'h8000_00AB);
    #2 resetn = 1'b0;
    #1;
    chk_val("t5_hreadyout", 32'(HREADYOUT), 32'd1);
    chk_val("t5_hresp", 32'(HRESP), 32'd0);
    chk_val("t5_hrdata", HRDATA, 32'h0);
    chk_val("t5_vld", 32'(cmd_wr_vld), 32'd0);
    chk_val("t5_addr", 32'(cmd_wr_addr), 32'h0);
    chk_val("t5_data", cmd_wr_data, 32'h0);
    #20 resetn = 1'b1;
    vc = vld_cycles;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    cmd_wr_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
    end
    chk_val("t5_no_vld_after", 32'(vld_cycles - vc), 32'd0);
    do_read(OFS_CTL0, rd, rd4, rr, rp);
    chk_val("t5_shadow_clr", rd, 32'h0);
    do_read(OFS_STATUS, rd, rd4, rr, rp);
    chk_val("t5_status_clr", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
